progmem_mc: RTL and testbench

- Parametrised, multi-channel program memory that replaces the inline combinational progmem array used by single-core benches.
- Serves N cores from one synchronous-read instruction store, using round-robin arbitration and a request/grant/valid handshake.
- Has a load port for writing programs without hierarchical assignment.
- After reset, an internal sequencer fills the whole store with NOP.

---
 rtl/progmem_mc_pkg.sv | 22 ++
 rtl/progmem_mc_rr_arbiter.sv | 48 ++++
 rtl/progmem_mc.sv | 139 +++++++++++++
 tb/tb_progmem_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/progmem_mc_pkg.sv
// Shared constants for the multi-channel program memory: instruction encoding,
// default widths and sequencer state encodings.
package progmem_mc_pkg;

  localparam int PM_INST_W      = 32;
  localparam int PM_INST_ADDR_W = 8;

  localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
  localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;

  // ADDI x0, x0, 0
  localparam logic [PM_INST_W-1:0] NOP_INST =
    {12'd0, 5'd0, FUNC3_ADD_SUB, 5'd0, OPCODE_ALUI};

  localparam logic [0:0] PM_INIT = 1'b0;
  localparam logic [0:0] PM_RUN  = 1'b1;

  function automatic logic pm_in_range(input logic [31:0] a, input int depth);
    return (a < $unsigned(depth));
  endfunction

endpackage

// File: rtl/progmem_mc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx_s;

  // Scan from the far end back towards the pointer so the closest requester wins last.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx_s = '0;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        idx_s = PW'((int'(ptr_q) + i) % N);
        if (req[idx_s]) begin
          gnt        = '0;
          gnt[idx_s] = 1'b1;
          ptr_d      = PW'((int'(idx_s) + 1) % N);
        end else begin
          gnt = gnt;
        end
      end
    end else begin
      gnt = '0;
    end
  end

  // Pointer register; holds whenever nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/progmem_mc.sv
// Multi-core program memory: one synchronous-read store shared by N cores through a
// round-robin arbiter, with a program load port and a NOP fill sequencer after reset.
module progmem_mc
  import progmem_mc_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = PM_INST_ADDR_W,
  parameter int INST_W  = PM_INST_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      busy,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  output logic [N_CORES-1:0]        gnt,
  output logic [N_CORES-1:0]        rvalid,
  output logic [N_CORES*INST_W-1:0] rdata,
  output logic [N_CORES-1:0]        err,
  input  logic                      load_we,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [INST_W-1:0]         load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  logic [INST_W-1:0]         mem [DEPTH];
  logic [0:0]                state_q, state_d;
  logic [IDX_W-1:0]          fill_q, fill_d;
  logic [N_CORES-1:0]        rvalid_q, rvalid_d;
  logic [N_CORES-1:0]        err_q, err_d;
  logic [N_CORES*INST_W-1:0] rdata_q, rdata_d;
  logic                      run_s, arb_en_s, we_s, rd_oor_s;
  logic [IDX_W-1:0]          wa_s;
  logic [INST_W-1:0]         wd_s, rd_word_s;
  logic [ADDR_W-1:0]         rd_addr_s;

  assign run_s    = (state_q == PM_RUN);
  // A load owns the cycle, so no fetch can collide with a write.
  assign arb_en_s = run_s & en & ~load_we;

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en_s),
    .req (req),
    .gnt (gnt)
  );

  // Fill sequencer and single write port: NOP fill in INIT, program loads in RUN.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    we_s    = 1'b0;
    wa_s    = fill_q;
    wd_s    = NOP_W;
    case (state_q)
      PM_INIT: begin
        we_s = 1'b1;
        if (fill_q == IDX_W'(DEPTH - 1)) begin
          state_d = PM_RUN;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + IDX_W'(1);
        end
      end
      PM_RUN: begin
        if (load_we && pm_in_range(32'(load_addr), DEPTH)) begin
          we_s = 1'b1;
          wa_s = IDX_W'(load_addr);
          wd_s = load_data;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        state_d = PM_INIT;
        fill_d  = '0;
      end
    endcase
  end

  // Grant is one-hot, so the winner's address is an OR of masked lanes.
  always_comb begin
    rd_addr_s = '0;
    for (int k = 0; k < N_CORES; k++) begin
      rd_addr_s = rd_addr_s | (addr[k*ADDR_W +: ADDR_W] & {ADDR_W{gnt[k]}});
    end
    rd_oor_s  = !pm_in_range(32'(rd_addr_s), DEPTH);
    rd_word_s = rd_oor_s ? NOP_W : mem[IDX_W'(rd_addr_s)];
  end

  // Next values of the per-core response registers; unserved lanes keep their data.
  always_comb begin
    rvalid_d = gnt;
    err_d    = '0;
    rdata_d  = rdata_q;
    for (int k = 0; k < N_CORES; k++) begin
      if (gnt[k]) begin
        rdata_d[k*INST_W +: INST_W] = rd_word_s;
        err_d[k]                    = rd_oor_s;
      end else begin
        err_d[k] = 1'b0;
      end
    end
  end

  // Sequencer state and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PM_INIT;
      fill_q   <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= {N_CORES{NOP_W}};
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Instruction store; contents are cleared by the fill, not by reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wa_s] <= wd_s;
    end
  end

  assign busy   = (state_q == PM_INIT);
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_progmem_mc.sv
// Bench for progmem_mc: DEPTH=256 and DEPTH=20 instances share stimulus and are
// compared against a behavioural model of the store, arbitration and fill timing.
module tb_progmem_mc;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int IW = 32;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, en, load_we;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [AW-1:0]   load_addr;
  logic [IW-1:0]   load_data;

  logic            busy_w   [2];
  logic [N-1:0]    gnt_w    [2];
  logic [N-1:0]    rvalid_w [2];
  logic [N-1:0]    err_w    [2];
  logic [N*IW-1:0] rdata_w  [2];

  int checks = 0;
  int errors = 0;

  int              dep [2] = '{256, 20};
  logic [IW-1:0]   mm [2][256];
  bit              mbusy [2];
  int              mfill [2];
  int              mptr [2];
  logic [N-1:0]    egnt [2];
  logic [N-1:0]    ervalid [2];
  logic [N-1:0]    eerr [2];
  logic [N-1:0]    ognt [2];
  logic            obusy [2];
  logic [N*IW-1:0] erd [2];

  always #5 clk = ~clk;

  progmem_mc #(.N_CORES(N), .DEPTH(256), .ADDR_W(AW), .INST_W(IW)) dut256 (
    .clk(clk), .rst(rst), .en(en), .busy(busy_w[0]), .req(req), .addr(addr),
    .gnt(gnt_w[0]), .rvalid(rvalid_w[0]), .rdata(rdata_w[0]), .err(err_w[0]),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

  progmem_mc #(.N_CORES(N), .DEPTH(20), .ADDR_W(AW), .INST_W(IW)) dut20 (
    .clk(clk), .rst(rst), .en(en), .busy(busy_w[1]), .req(req), .addr(addr),
    .gnt(gnt_w[1]), .rvalid(rvalid_w[1]), .rdata(rdata_w[1]), .err(err_w[1]),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mbusy[d]   = 1'b1;
      mfill[d]   = 0;
      mptr[d]    = 0;
      egnt[d]    = '0;
      ervalid[d] = '0;
      eerr[d]    = '0;
      erd[d]     = {N{NOP}};
    end
  endtask

  function automatic logic [N-1:0] arb(int d);
    logic [N-1:0] g;
    g = '0;
    if (rst || mbusy[d] || !en || load_we) return g;
    for (int i = 0; i < N; i++) begin
      if (req[(mptr[d] + i) % N]) begin
        g[(mptr[d] + i) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(int d);
    int a;
    ervalid[d] = egnt[d];
    eerr[d]    = '0;
    if (mbusy[d]) begin
      mm[d][mfill[d]] = NOP;
      mfill[d]++;
      if (mfill[d] == dep[d]) mbusy[d] = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (egnt[d][k]) begin
          a = int'(addr[k*AW +: AW]);
          if (a < dep[d]) erd[d][k*IW +: IW] = mm[d][a];
          else begin
            erd[d][k*IW +: IW] = NOP;
            eerr[d][k] = 1'b1;
          end
          mptr[d] = (k + 1) % N;
        end
      end
      if (load_we && int'(load_addr) < dep[d]) mm[d][load_addr] = load_data;
    end
  endtask

  // One clock: snapshot combinational outputs mid-cycle, then advance model with the edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      egnt[d]  = arb(d);
      ognt[d]  = gnt_w[d];
      obusy[d] = busy_w[d];
    end
    @(posedge clk);
    if (rst) model_reset();
    else for (int d = 0; d < 2; d++) model_edge(d);
    #1;
  endtask

  task automatic set_addr(int k, int a);
    addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    int cnt [2];
    int cyc;
    rst = 1'b1; en = 1'b1; req = '0; addr = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    model_reset();
    step(); step();
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy_w[d] !== 1'b1) begin errors++; $display("FAIL reset_busy dut%0d got %b want 1", d, busy_w[d]); end
      checks++; if (gnt_w[d] !== 4'b0000) begin errors++; $display("FAIL reset_gnt dut%0d got %b want 0000", d, gnt_w[d]); end
      checks++; if (rvalid_w[d] !== 4'b0000) begin errors++; $display("FAIL reset_rvalid dut%0d got %b want 0000", d, rvalid_w[d]); end
      checks++; if (err_w[d] !== 4'b0000) begin errors++; $display("FAIL reset_err dut%0d got %b want 0000", d, err_w[d]); end
      checks++; if (rdata_w[d] !== {N{NOP}}) begin errors++; $display("FAIL reset_rdata dut%0d got %h want %h", d, rdata_w[d], {N{NOP}}); end
    end
    // Loads and requests during INIT must be ignored by the 256-deep store.
    rst = 1'b0; req = 4'hF; load_we = 1'b1; load_addr = 8'd5; load_data = 32'hCAFE_0005;
    cnt = '{0, 0}; cyc = 0;
    do begin
      step(); cyc++;
      if (cyc == 150) load_we = 1'b0;
      for (int d = 0; d < 2; d++) if (obusy[d]) cnt[d]++;
      if (obusy[0]) begin
        checks++; if (ognt[0] !== 4'b0000) begin errors++; $display("FAIL init_gnt cycle %0d got %b want 0000", cyc, ognt[0]); end
      end
    end while (obusy[0] && cyc < 400);
    checks++; if (cnt[0] != 256) begin errors++; $display("FAIL busy_len256 got %0d want 256", cnt[0]); end
    checks++; if (cnt[1] != 20) begin errors++; $display("FAIL busy_len20 got %0d want 20", cnt[1]); end
    load_we = 1'b0;
  endtask

  task automatic test_first_read();
    req = 4'b0001; addr = '0; set_addr(0, 5);
    step();
    checks++; if (ognt[0] !== 4'b0001) begin errors++; $display("FAIL first_gnt got %b want 0001", ognt[0]); end
    checks++; if (rvalid_w[0] !== 4'b0001) begin errors++; $display("FAIL first_rvalid got %b want 0001", rvalid_w[0]); end
    checks++; if (rdata_w[0][31:0] !== NOP) begin errors++; $display("FAIL first_rdata got %h want %h", rdata_w[0][31:0], NOP); end
    checks++; if (err_w[0][0] !== 1'b0) begin errors++; $display("FAIL first_err got %b want 0", err_w[0][0]); end
    checks++; if (rdata_w[1][31:0] !== erd[1][31:0]) begin errors++; $display("FAIL first_rdata20 got %h want %h", rdata_w[1][31:0], erd[1][31:0]); end
    req = '0;
    step();
  endtask

  task automatic test_load_single();
    logic [IW-1:0] w;
    w = {12'd2, 5'd0, 3'b000, 5'd0, 7'b0010011};
    req = '0; load_we = 1'b1; load_addr = 8'd0; load_data = w;
    step();
    load_we = 1'b0; req = 4'b0100; set_addr(2, 0);
    step();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ognt[d] !== 4'b0100) begin errors++; $display("FAIL single_gnt dut%0d got %b want 0100", d, ognt[d]); end
      checks++; if (rvalid_w[d] !== 4'b0100) begin errors++; $display("FAIL single_rvalid dut%0d got %b want 0100", d, rvalid_w[d]); end
      checks++; if (rdata_w[d][95:64] !== w) begin errors++; $display("FAIL single_rdata dut%0d got %h want %h", d, rdata_w[d][95:64], w); end
    end
    req = '0;
    step(); step(); step();
    for (int d = 0; d < 2; d++) begin
      checks++; if (rvalid_w[d] !== 4'b0000) begin errors++; $display("FAIL single_idle_rvalid dut%0d got %b want 0000", d, rvalid_w[d]); end
      checks++; if (rdata_w[d][95:64] !== w) begin errors++; $display("FAIL single_hold dut%0d got %h want %h", d, rdata_w[d][95:64], w); end
    end
  endtask

  task automatic test_all_contend();
    logic [IW-1:0] words [N];
    logic [N-1:0]  seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1000;
    step();
    req = '0;
    for (int i = 0; i < N; i++) begin
      words[i] = $urandom;
      load_we = 1'b1; load_addr = AW'(10 + i); load_data = words[i];
      step();
    end
    load_we = 1'b0; req = 4'hF;
    for (int k = 0; k < N; k++) set_addr(k, 10 + k);
    for (int s = 0; s < 5; s++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++; if (ognt[d] !== seq[s]) begin errors++; $display("FAIL rr_gnt dut%0d step %0d got %b want %b", d, s, ognt[d], seq[s]); end
        checks++; if (rvalid_w[d] !== seq[s]) begin errors++; $display("FAIL rr_rvalid dut%0d step %0d got %b want %b", d, s, rvalid_w[d], seq[s]); end
      end
    end
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++) begin
        checks++; if (rdata_w[d][k*IW +: IW] !== words[k]) begin errors++; $display("FAIL rr_rdata dut%0d lane %0d got %h want %h", d, k, rdata_w[d][k*IW +: IW], words[k]); end
      end
  endtask

  task automatic test_load_stall();
    logic [IW-1:0] words [3];
    logic [N-1:0]  seq [2];
    seq = '{4'b0010, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      load_we = 1'b1; load_addr = AW'(14 + i); load_data = words[i];
      step();
      for (int d = 0; d < 2; d++) begin
        checks++; if (ognt[d] !== 4'b0000) begin errors++; $display("FAIL stall_gnt dut%0d cyc %0d got %b want 0000", d, i, ognt[d]); end
      end
    end
    load_we = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++; if (ognt[d] !== seq[s]) begin errors++; $display("FAIL stall_resume dut%0d got %b want %b", d, ognt[d], seq[s]); end
      end
    end
    req = 4'b0001; set_addr(0, 15);
    step();
    for (int d = 0; d < 2; d++) begin
      checks++; if (rdata_w[d][31:0] !== words[1]) begin errors++; $display("FAIL stall_commit dut%0d got %h want %h", d, rdata_w[d][31:0], words[1]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [IW-1:0] prev5;
    req = 4'b0010; set_addr(1, 25);
    step();
    checks++; if (rvalid_w[1] !== 4'b0010) begin errors++; $display("FAIL oor_rvalid got %b want 0010", rvalid_w[1]); end
    checks++; if (err_w[1] !== 4'b0010) begin errors++; $display("FAIL oor_err got %b want 0010", err_w[1]); end
    checks++; if (rdata_w[1][63:32] !== NOP) begin errors++; $display("FAIL oor_rdata got %h want %h", rdata_w[1][63:32], NOP); end
    checks++; if (err_w[0] !== 4'b0000) begin errors++; $display("FAIL oor_err256 got %b want 0000", err_w[0]); end
    prev5 = mm[1][5];
    req = '0; load_we = 1'b1; load_addr = 8'd25; load_data = 32'hDEAD_BEEF;
    step();
    load_we = 1'b0; req = 4'b0001; set_addr(0, 5);
    step();
    checks++; if (rdata_w[1][31:0] !== prev5) begin errors++; $display("FAIL oor_alias got %h want %h", rdata_w[1][31:0], prev5); end
    set_addr(0, 25);
    step();
    checks++; if (rdata_w[0][31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_load256 got %h want deadbeef", rdata_w[0][31:0]); end
    checks++; if (err_w[1] !== 4'b0001) begin errors++; $display("FAIL oor_err20_lane0 got %b want 0001", err_w[1]); end
  endtask

  task automatic test_en_low();
    logic [IW-1:0] w;
    w = $urandom;
    req = 4'hF; en = 1'b0;
    step();
    load_we = 1'b1; load_addr = 8'd7; load_data = w;
    step();
    load_we = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ognt[d] !== 4'b0000) begin errors++; $display("FAIL en_gnt dut%0d got %b want 0000", d, ognt[d]); end
      checks++; if (rvalid_w[d] !== 4'b0000) begin errors++; $display("FAIL en_rvalid dut%0d got %b want 0000", d, rvalid_w[d]); end
      checks++; if (rdata_w[d] !== erd[d]) begin errors++; $display("FAIL en_hold dut%0d got %h want %h", d, rdata_w[d], erd[d]); end
    end
    en = 1'b1; req = 4'b0001; set_addr(0, 7);
    step();
    for (int d = 0; d < 2; d++) begin
      checks++; if (rdata_w[d][31:0] !== w) begin errors++; $display("FAIL en_load dut%0d got %h want %h", d, rdata_w[d][31:0], w); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req = N'($urandom_range(0, 15));
      addr = $urandom & 32'h1F1F_1F1F;
      en = ($urandom_range(0, 9) != 0);
      load_we = ($urandom_range(0, 7) == 0);
      load_addr = AW'($urandom_range(0, 31));
      load_data = $urandom;
      step();
      for (int d = 0; d < 2; d++) begin
        checks++; if (ognt[d] !== egnt[d]) begin errors++; $display("FAIL rnd_gnt dut%0d cyc %0d got %b want %b", d, c, ognt[d], egnt[d]); end
        checks++; if (rvalid_w[d] !== ervalid[d]) begin errors++; $display("FAIL rnd_rvalid dut%0d cyc %0d got %b want %b", d, c, rvalid_w[d], ervalid[d]); end
        checks++; if (err_w[d] !== eerr[d]) begin errors++; $display("FAIL rnd_err dut%0d cyc %0d got %b want %b", d, c, err_w[d], eerr[d]); end
        checks++; if (rdata_w[d] !== erd[d]) begin errors++; $display("FAIL rnd_rdata dut%0d cyc %0d got %h want %h", d, c, rdata_w[d], erd[d]); end
        checks++; if ($countones(rvalid_w[d]) > 1) begin errors++; $display("FAIL rnd_onehot dut%0d cyc %0d got %b want at most one bit", d, c, rvalid_w[d]); end
      end
    end
    load_we = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    int cyc;
    req = 4'b0010; addr = '0; set_addr(1, 25);
    step();
    checks++; if (err_w[1] !== 4'b0010) begin errors++; $display("FAIL pre_rst_err got %b want 0010", err_w[1]); end
    #1 rst = 1'b1; model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (rvalid_w[d] !== 4'b0000) begin errors++; $display("FAIL arst_rvalid dut%0d got %b want 0000", d, rvalid_w[d]); end
      checks++; if (err_w[d] !== 4'b0000) begin errors++; $display("FAIL arst_err dut%0d got %b want 0000", d, err_w[d]); end
      checks++; if (gnt_w[d] !== 4'b0000) begin errors++; $display("FAIL arst_gnt dut%0d got %b want 0000", d, gnt_w[d]); end
      checks++; if (rdata_w[d] !== {N{NOP}}) begin errors++; $display("FAIL arst_rdata dut%0d got %h want %h", d, rdata_w[d], {N{NOP}}); end
    end
    step(); step();
    rst = 1'b0; req = 4'hF;
    repeat (10) step();
    #1 rst = 1'b1; model_reset();
    #1;
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL mid_init_busy got %b want 1", busy_w[0]); end
    checks++; if (gnt_w[1] !== 4'b0000) begin errors++; $display("FAIL mid_init_gnt20 got %b want 0000", gnt_w[1]); end
    step(); step();
    rst = 1'b0;
    cnt = 0; cyc = 0;
    do begin
      step(); cyc++;
      if (obusy[0]) begin
        cnt++;
        checks++; if (ognt[0] !== 4'b0000) begin errors++; $display("FAIL refill_gnt cycle %0d got %b want 0000", cyc, ognt[0]); end
      end
    end while (obusy[0] && cyc < 400);
    checks++; if (cnt != 256) begin errors++; $display("FAIL refill_len got %0d want 256", cnt); end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_load_single();
    test_all_contend();
    test_load_stall();
    test_out_of_range();
    test_en_low();
    test_random();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
